sega_pad_scanner: RTL and testbench

- Polls a Sega Mega Drive 3/6-button gamepad on the DB9 joystick connector by toggling the pad SELECT line.
- Decodes the sampled pins into an active-high Kempston byte that feeds the port logic directly as kempston_data. The port logic uses it for both the Kempston port read and the Sinclair-joystick keyboard overlay.
- Also reports pad presence, 6-button detection and the extra X/Y/Z/MODE buttons.

---
 rtl/sega_pad_scanner_if.sv | 46 ++++
 rtl/sega_pad_scanner.sv | 194 +++++++++++++++++++
 tb/tb_sega_pad_scanner.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sega_pad_scanner_if.sv
// DB9 Mega Drive pad pins plus decoded joystick results.
// master = scanner side, slave = connector/port-logic side.
interface sega_pad_scanner_if;
    logic       en;
    logic       joy_up;
    logic       joy_down;
    logic       joy_left;
    logic       joy_right;
    logic       joy_b;
    logic       joy_c;
    logic       joy_sel;
    logic [7:0] kempston_data;
    logic       pad_present;
    logic       pad_6btn;
    logic [3:0] xyzm;

    modport master (
        input  en,
        input  joy_up,
        input  joy_down,
        input  joy_left,
        input  joy_right,
        input  joy_b,
        input  joy_c,
        output joy_sel,
        output kempston_data,
        output pad_present,
        output pad_6btn,
        output xyzm
    );

    modport slave (
        output en,
        output joy_up,
        output joy_down,
        output joy_left,
        output joy_right,
        output joy_b,
        output joy_c,
        input  joy_sel,
        input  kempston_data,
        input  pad_present,
        input  pad_6btn,
        input  xyzm
    );
endinterface

// File: rtl/sega_pad_scanner.sv
// Mega Drive 3/6-button pad poller: toggles SELECT, samples the pins,
// and publishes an active-high Kempston byte once per frame.
module sega_pad_scanner #(
    parameter int PHASE_CYCLES = 280,
    parameter int IDLE_CYCLES  = 56000
) (
    input  logic              clk28,
    input  logic              rst_n,
    sega_pad_scanner_if.master pad
);
    localparam int PW = $clog2(PHASE_CYCLES);
    localparam int IW = $clog2(IDLE_CYCLES);
    localparam int CW = (IW > PW) ? IW : PW;
    localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
    localparam logic [CW-1:0] PH_LAST   = CW'(PHASE_CYCLES - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    phase, phase_d;

    logic [5:0] sync1, sync2;
    logic [5:0] prs;

    logic sel_d, upd_d, upd_q, sel_q;
    logic smp0, smp1, smp5, smp6;

    logic [3:0] sh_dir;
    logic       sh_b, sh_c, sh_a, sh_st;
    logic       sh_pres, sh_six;
    logic [3:0] sh_xyzm;

    logic [7:0] kd_q;
    logic       pres_q, six_q;
    logic [3:0] xyzm_q;

    // {up,down,left,right,b,c}; pins idle high through pull-ups
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {pad.joy_up, pad.joy_down, pad.joy_left,
                      pad.joy_right, pad.joy_b, pad.joy_c};
            sync2 <= sync1;
        end
    end

    assign prs = ~sync2;

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            phase <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            phase <= phase_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        phase_d = phase;
        unique case (state)
            IDLE: begin
                if (!pad.en) begin
                    cnt_d = '0;
                end else if (cnt == IDLE_LAST) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                    phase_d = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            SCAN: begin
                if (!pad.en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    phase_d = '0;
                end else if (cnt == PH_LAST) begin
                    cnt_d = '0;
                    if (phase == 3'd7) begin
                        state_d = IDLE;
                        phase_d = '0;
                    end else begin
                        phase_d = phase + 3'd1;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_d = (state_d == IDLE) ? 1'b1 : ~phase_d[0];
        upd_d = 1'b0;
        smp0  = 1'b0;
        smp1  = 1'b0;
        smp5  = 1'b0;
        smp6  = 1'b0;
        if (pad.en && state == SCAN && cnt == PH_LAST) begin
            unique case (1'b1)
                phase == 3'd0: smp0  = 1'b1;
                phase == 3'd1: smp1  = 1'b1;
                phase == 3'd5: smp5  = 1'b1;
                phase == 3'd6: smp6  = 1'b1;
                phase == 3'd7: upd_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= 1'b1;
            upd_q <= 1'b0;
        end else begin
            sel_q <= sel_d;
            upd_q <= upd_d;
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            sh_dir  <= '0;
            sh_b    <= 1'b0;
            sh_c    <= 1'b0;
            sh_a    <= 1'b0;
            sh_st   <= 1'b0;
            sh_pres <= 1'b0;
            sh_six  <= 1'b0;
            sh_xyzm <= '0;
        end else if (!pad.en) begin
            sh_dir  <= '0;
            sh_b    <= 1'b0;
            sh_c    <= 1'b0;
            sh_a    <= 1'b0;
            sh_st   <= 1'b0;
            sh_pres <= 1'b0;
            sh_six  <= 1'b0;
            sh_xyzm <= '0;
        end else begin
            if (smp0) begin
                sh_dir <= prs[5:2];
                sh_b   <= prs[1];
                sh_c   <= prs[0];
            end
            if (smp1) begin
                sh_pres <= prs[3] & prs[2];
                sh_a    <= prs[1];
                sh_st   <= prs[0];
            end
            if (smp5) begin
                sh_six <= &prs[5:2];
            end
            // 6-button high phase: up/down/left/right carry Z/Y/X/MODE
            if (smp6) begin
                sh_xyzm <= sh_six ? {prs[2], prs[3], prs[4], prs[5]} : 4'd0;
            end
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            kd_q   <= '0;
            pres_q <= 1'b0;
            six_q  <= 1'b0;
            xyzm_q <= '0;
        end else if (!pad.en) begin
            kd_q   <= '0;
            pres_q <= 1'b0;
            six_q  <= 1'b0;
            xyzm_q <= '0;
        end else if (upd_q) begin
            kd_q   <= sh_pres ? {sh_st, sh_a, sh_c, sh_b, sh_dir} : 8'd0;
            pres_q <= sh_pres;
            six_q  <= sh_pres & sh_six;
            xyzm_q <= sh_pres ? sh_xyzm : 4'd0;
        end
    end

    assign pad.joy_sel       = sel_q;
    assign pad.kempston_data = kd_q;
    assign pad.pad_present   = pres_q;
    assign pad.pad_6btn      = six_q;
    assign pad.xyzm          = xyzm_q;
endmodule

// File: tb/tb_sega_pad_scanner.sv
// Directed bench for sega_pad_scanner with a behavioural 3/6-button pad.
// Short phase/idle parameters keep each frame to a hundred or so cycles.
module tb_sega_pad_scanner;
    localparam int P = 8;
    localparam int I = 40;
    localparam int F = I + 8 * P;

    logic clk28 = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b1;

    int mode = 0;
    logic b_up = 0, b_down = 0, b_left = 0, b_right = 0;
    logic b_a = 0, b_b = 0, b_c = 0, b_start = 0;
    logic b_x = 0, b_y = 0, b_z = 0, b_mode = 0;

    logic p_up, p_down, p_left, p_right, p_b, p_c;

    int n_chk  = 0;
    int n_fail = 0;
    int e      = 0;
    int base   = 0;

    int   lows    = 0;
    int   hi_run  = 0;
    logic sel_old = 1'b1;

    sega_pad_scanner_if bus ();

    sega_pad_scanner #(
        .PHASE_CYCLES(P),
        .IDLE_CYCLES (I)
    ) dut (
        .clk28(clk28),
        .rst_n(rst_n),
        .pad  (bus.master)
    );

    always #5 clk28 = ~clk28;

    assign bus.en        = en;
    assign bus.joy_up    = p_up;
    assign bus.joy_down  = p_down;
    assign bus.joy_left  = p_left;
    assign bus.joy_right = p_right;
    assign bus.joy_b     = p_b;
    assign bus.joy_c     = p_c;

    // pad counts SELECT falling edges, forgetting them after a long high
    always @(negedge clk28) begin
        if (sel_old && !bus.joy_sel) lows = lows + 1;
        if (bus.joy_sel) hi_run = hi_run + 1;
        else hi_run = 0;
        if (hi_run >= 3 * P) lows = 0;
        sel_old = bus.joy_sel;
    end

    always_comb begin
        p_up    = 1'b1;
        p_down  = 1'b1;
        p_left  = 1'b1;
        p_right = 1'b1;
        p_b     = 1'b1;
        p_c     = 1'b1;
        if (mode != 0) begin
            if (bus.joy_sel) begin
                if (mode == 2 && lows == 3) begin
                    p_up    = ~b_z;
                    p_down  = ~b_y;
                    p_left  = ~b_x;
                    p_right = ~b_mode;
                end else begin
                    p_up    = ~b_up;
                    p_down  = ~b_down;
                    p_left  = ~b_left;
                    p_right = ~b_right;
                end
                p_b = ~b_b;
                p_c = ~b_c;
            end else begin
                if (mode == 2 && lows == 3) begin
                    p_up   = 1'b0;
                    p_down = 1'b0;
                end else begin
                    p_up   = ~b_up;
                    p_down = ~b_down;
                end
                p_left  = 1'b0;
                p_right = 1'b0;
                p_b     = ~b_a;
                p_c     = ~b_start;
            end
        end
    end

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_sel(input int m);
        if (m < I) return 1'b1;
        return (((m - I) / P) % 2) == 0;
    endfunction

    task automatic tick;
        @(posedge clk28);
        #1;
        e = e + 1;
    endtask

    task automatic run_to(input int target);
        int guard;
        int m;
        guard = 0;
        do begin
            tick();
            m = (e - base) % F;
            chk("sel", 8'(bus.joy_sel), 8'(exp_sel(m)));
            guard = guard + 1;
        end while (m != target && guard < 2 * F);
        if (guard >= 2 * F) chk("timeout", 8'd1, 8'd0);
    endtask

    task automatic next_out;
        run_to(0);
        run_to(1);
    endtask

    task automatic chk_out(input string tag, input logic [7:0] kd,
                           input logic pr, input logic six,
                           input logic [3:0] xm);
        chk({tag, "_kd"}, bus.kempston_data, kd);
        chk({tag, "_pres"}, 8'(bus.pad_present), 8'(pr));
        chk({tag, "_6btn"}, 8'(bus.pad_6btn), 8'(six));
        chk({tag, "_xyzm"}, 8'(bus.xyzm), 8'(xm));
    endtask

    task automatic clear_btn;
        {b_up, b_down, b_left, b_right} = '0;
        {b_a, b_b, b_c, b_start} = '0;
        {b_x, b_y, b_z, b_mode} = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk28);
        #1;
        chk("rst_sel", 8'(bus.joy_sel), 8'd1);
        chk_out("rst", 8'h00, 1'b0, 1'b0, 4'h0);
        rst_n = 1'b1;
        base  = e;

        for (int f = 0; f < 3; f++) begin
            next_out();
            chk_out("nopad", 8'h00, 1'b0, 1'b0, 4'h0);
        end

        mode = 1;
        clear_btn();
        b_right = 1; b_b = 1; b_start = 1;
        next_out();
        chk_out("pad3", 8'h91, 1'b1, 1'b0, 4'h0);

        mode = 2;
        clear_btn();
        b_up = 1; b_a = 1; b_x = 1; b_mode = 1;
        next_out();
        chk_out("pad6", 8'h48, 1'b1, 1'b1, 4'b1100);

        mode = 1;
        clear_btn();
        b_start = 1;
        next_out();
        chk("start_kd", bus.kempston_data, 8'h80);
        run_to(I + P + 2);
        b_b = 1;
        run_to(0);
        chk("late_pre_kd", bus.kempston_data, 8'h80);
        run_to(1);
        chk("late_kd", bus.kempston_data, 8'h80);
        next_out();
        chk("late_next_kd", bus.kempston_data, 8'h90);

        run_to(I + 3 * P + 2);
        en = 1'b0;
        tick();
        chk("abort_sel", 8'(bus.joy_sel), 8'd1);
        chk_out("abort", 8'h00, 1'b0, 1'b0, 4'h0);
        repeat (5) tick();
        chk("off_kd", bus.kempston_data, 8'h00);
        chk("off_sel", 8'(bus.joy_sel), 8'd1);
        en   = 1'b1;
        base = e;
        run_to(I + P);
        run_to(0);
        chk("reen_pre_kd", bus.kempston_data, 8'h00);
        run_to(1);
        chk_out("reen", 8'h90, 1'b1, 1'b0, 4'h0);

        run_to(I + 6 * P + 3);
        rst_n = 1'b0;
        #1;
        chk("arst_sel", 8'(bus.joy_sel), 8'd1);
        chk_out("arst", 8'h00, 1'b0, 1'b0, 4'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        base  = e;
        run_to(0);
        chk("arst_pre_kd", bus.kempston_data, 8'h00);
        run_to(1);
        chk_out("arst_first", 8'h90, 1'b1, 1'b0, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
